// File: rtl/pulse_tx_sync_if.sv
// Bus for the source side of the toggle pulse synchronizer.
// Optional overflow flag ports exist only when PULSE_TX_SYNC_OVF_EN is defined.
// master: the event source / environment; slave: the pulse_tx_sync block.
interface pulse_tx_sync_if #(
  parameter int CNT_W = 4
);
  logic             src_pulse;
  logic             dst_ack_toggle;
  logic             src_toggle;
  logic             src_busy;
  logic [CNT_W-1:0] src_pending;
  logic             src_full;
`ifdef PULSE_TX_SYNC_OVF_EN
  logic             src_ovf_clr;
  logic             src_ovf;

  modport master (
    output src_pulse, dst_ack_toggle, src_ovf_clr,
    input  src_toggle, src_busy, src_pending, src_full, src_ovf
  );
  modport slave (
    input  src_pulse, dst_ack_toggle, src_ovf_clr,
    output src_toggle, src_busy, src_pending, src_full, src_ovf
  );
`else
  modport master (
    output src_pulse, dst_ack_toggle,
    input  src_toggle, src_busy, src_pending, src_full
  );
  modport slave (
    input  src_pulse, dst_ack_toggle,
    output src_toggle, src_busy, src_pending, src_full
  );
`endif
endinterface

// File: rtl/pulse_tx_sync.sv
// Source-domain transmitter of the toggle pulse synchronizer.
// Each accepted src_pulse becomes one src_toggle transition; events arriving
// while a transfer is outstanding wait in a saturating pending counter.
// Optional: define PULSE_TX_SYNC_OVF_EN to add a sticky overflow flag
// (src_ovf) with its clear input (src_ovf_clr).
//
// state      | meaning
// S_IDLE     | nothing in flight, src_toggle matches the last ack
// S_WAIT_ACK | a toggle was launched, waiting for ack_s to match it
module pulse_tx_sync #(
  parameter int DEPTH   = 2,
  parameter int CNT_W   = 4,
  parameter bit RST_VAL = 1'b0
) (
  input logic              src_clk,
  input logic              src_rst_n,
  pulse_tx_sync_if.slave   bus
);

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_ACK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_MAX = '1;
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DEPTH-1:0] r_ack_sync;
  logic             r_toggle;
  logic [CNT_W-1:0] r_pending;

  logic w_ack_s;
  logic w_ack_match;
  logic w_launch_ok;
  logic w_want;
  logic w_launch;
  logic w_from_q;
  logic w_inc;
  logic w_dec;
  logic w_full;
  logic w_drop;

  assign w_ack_s = r_ack_sync[DEPTH-1];
  assign w_full  = (r_pending == C_MAX);

  // Bring the asynchronous ack toggle into src_clk through a DEPTH-flop chain.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      r_ack_sync <= {DEPTH{RST_VAL}};
    end else begin
      r_ack_sync <= {r_ack_sync[DEPTH-2:0], bus.dst_ack_toggle};
    end
  end

  // Launch decision and queue bookkeeping; an idle queue lets a pulse bypass it.
  always_comb begin
    w_ack_match = (w_ack_s == r_toggle);
    w_launch_ok = (r_state == S_IDLE) || w_ack_match;
    w_want      = bus.src_pulse || (r_pending != '0);
    w_launch    = w_launch_ok && w_want;
    w_from_q    = w_launch && (r_pending != '0);
    w_inc       = bus.src_pulse && !(w_launch && (r_pending == '0));
    w_dec       = w_from_q;
    w_drop      = w_inc && !w_dec && w_full;
  end

  // Next-state logic: a launch always lands in WAIT_ACK, so back-to-back
  // transfers never pass through IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_launch) w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (w_ack_match && !w_want) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outgoing toggle flips once per launched event.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      r_toggle <= RST_VAL;
    end else if (w_launch) begin
      r_toggle <= ~r_toggle;
    end
  end

  // Pending counter saturates at full; an inc that would wrap is dropped.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      r_pending <= '0;
    end else if (w_inc && !w_dec && !w_full) begin
      r_pending <= r_pending + C_ONE;
    end else if (w_dec && !w_inc) begin
      r_pending <= r_pending - C_ONE;
    end
  end

`ifdef PULSE_TX_SYNC_OVF_EN
  logic r_ovf;

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge src_clk) begin
    if (!src_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (bus.src_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.src_ovf = r_ovf;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

  assign bus.src_toggle  = r_toggle;
  assign bus.src_busy    = (r_state == S_WAIT_ACK);
  assign bus.src_pending = r_pending;
  assign bus.src_full    = w_full;

endmodule

// File: tb/tb_pulse_tx_sync.sv
// Bench for pulse_tx_sync: directed scenarios followed by random traffic, all
// compared each cycle with an event-counting reference model. The destination
// is emulated as a 3-cycle loopback of src_toggle onto dst_ack_toggle.
module tb_pulse_tx_sync;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int LOOP  = 3;
  localparam int N     = 8192;
  localparam int MAXP  = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pulse_tx_sync_if #(.CNT_W(CNT_W)) bus ();

  pulse_tx_sync #(.DEPTH(DEPTH), .CNT_W(CNT_W), .RST_VAL(1'b0)) dut (
    .src_clk   (clk),
    .src_rst_n (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  // Per-cycle histories: reset asserted, ack driven, model toggle value.
  bit rl       [N];
  bit ack_hist [N];
  bit tog_hist [N];

  bit m_tog, m_busy, m_ovf;
  int m_pend;

  int obs_trans, obs_peak, obs_target;
  bit obs_prev_tog, obs_gap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Synchronized ack seen by the DUT this cycle: the ack driven DEPTH cycles ago,
  // or the reset value if reset hit the chain since then.
  function automatic bit calc_acks();
    return (rl[cyc-1] || rl[cyc-2]) ? 1'b0 : ack_hist[cyc-2];
  endfunction

  // One clock cycle. mode: 0 loopback, 1 ack frozen, 2 ack flipped once.
  task automatic step(input bit p, input bit rn, input int mode, input bit clr);
    bit ackv, acks, ok, want, launch, fromq, acc, drop;
    bit nt, nb, nov;
    int np;
    rl[cyc] = !rn;
    if (rl[cyc] || rl[cyc-1] || rl[cyc-2] || rl[cyc-3]) ackv = 1'b0;
    else if (mode == 1) ackv = ack_hist[cyc-1];
    else if (mode == 2) ackv = !ack_hist[cyc-1];
    else ackv = tog_hist[cyc-LOOP];
    ack_hist[cyc] = ackv;
    rst_n              = rn;
    bus.src_pulse      = p;
    bus.dst_ack_toggle = ackv;
`ifdef PULSE_TX_SYNC_OVF_EN
    bus.src_ovf_clr    = clr;
`endif
    acks = calc_acks();
    if (!rn) begin
      nt = 1'b0; nb = 1'b0; np = 0; nov = 1'b0;
    end else begin
      ok     = !m_busy || (acks == m_tog);
      want   = p || (m_pend > 0);
      launch = ok && want;
      fromq  = launch && (m_pend > 0);
      acc    = p && !(launch && m_pend == 0);
      np     = m_pend + (acc ? 1 : 0) - (fromq ? 1 : 0);
      drop   = (np > MAXP);
      if (drop) np = MAXP;
      nt  = m_tog ^ launch;
      nb  = launch || (m_busy && !ok);
      nov = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    end
    @(posedge clk);
    #1;
    cyc++;
    m_tog = nt; m_busy = nb; m_pend = np; m_ovf = nov;
    tog_hist[cyc] = m_tog;
    if (bus.src_toggle !== obs_prev_tog) obs_trans++;
    obs_prev_tog = bus.src_toggle;
    if (int'(bus.src_pending) > obs_peak) obs_peak = int'(bus.src_pending);
    if (obs_trans > 0 && obs_trans < obs_target && bus.src_busy !== 1'b1) obs_gap = 1'b1;
    chk("toggle",  bus.src_toggle,  m_tog);
    chk("busy",    bus.src_busy,    m_busy);
    chk("pending", bus.src_pending, m_pend);
    chk("full",    bus.src_full,    (m_pend == MAXP));
`ifdef PULSE_TX_SYNC_OVF_EN
    chk("ovf",     bus.src_ovf,     m_ovf);
`endif
  endtask

  task automatic obs_clear();
    obs_trans = 0; obs_peak = 0; obs_gap = 1'b0; obs_target = 0;
    obs_prev_tog = bus.src_toggle;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
  endtask

  int cnt;
  int mode;
  bit prev_tog;

  initial begin
    for (int i = 0; i < N; i++) begin
      rl[i] = 1'b1; ack_hist[i] = 1'b0; tog_hist[i] = 1'b0;
    end
    cyc = 4;
    m_tog = 0; m_busy = 0; m_pend = 0; m_ovf = 0;
    rst_n = 1'b0;
    bus.src_pulse = 1'b0;
    bus.dst_ack_toggle = 1'b0;
`ifdef PULSE_TX_SYNC_OVF_EN
    bus.src_ovf_clr = 1'b0;
`endif
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("rst_toggle",  bus.src_toggle,  0);
    chk("rst_busy",    bus.src_busy,    0);
    chk("rst_pending", bus.src_pending, 0);
    chk("rst_full",    bus.src_full,    0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    obs_clear();

    // Single event: bypass launch, busy clears 6 cycles after the toggle.
    step(1, 1, 0, 0);
    chk("single_toggle", bus.src_toggle, 1);
    chk("single_busy",   bus.src_busy,   1);
    cnt = 0;
    while (bus.src_busy === 1'b1 && cnt < 20) begin step(0, 1, 0, 0); cnt++; end
    chk("single_latency", cnt, 6);
    chk("single_peak", obs_peak, 0);

    // Burst of 5 pulses: back-to-back launches, queue peaks at 4.
    do_reset();
    obs_clear();
    obs_target = 5;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    cnt = 0;
    while (bus.src_busy === 1'b1 && cnt < 80) begin step(0, 1, 0, 0); cnt++; end
    chk("burst_drained", bus.src_busy, 0);
    chk("burst_trans",   obs_trans, 5);
    chk("burst_peak",    obs_peak, 4);
    chk("burst_gap",     obs_gap, 0);
    chk("burst_final",   bus.src_toggle, 1);

    // Saturation with a frozen ack: 17 pulses leave 15 queued, 1 dropped.
    do_reset();
    obs_clear();
    for (int i = 0; i < 17; i++) step(1, 1, 1, 0);
    chk("sat_pending", bus.src_pending, 15);
    chk("sat_full",    bus.src_full, 1);
`ifdef PULSE_TX_SYNC_OVF_EN
    chk("sat_ovf_set", bus.src_ovf, 1);
    step(0, 1, 1, 1);
    chk("sat_ovf_clr", bus.src_ovf, 0);
`endif
    step(0, 1, 1, 0);
    cnt = 0;
    while (bus.src_busy === 1'b1 && cnt < 300) begin step(0, 1, 0, 0); cnt++; end
    chk("sat_drained", bus.src_busy, 0);
    chk("sat_trans",   obs_trans, 16);

    // Pulse on the ack-match cycle with 3 queued: launch from queue, net 0.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    cnt = 0;
    while (!(m_busy && calc_acks() == m_tog) && cnt < 20) begin step(0, 1, 0, 0); cnt++; end
    chk("coinc_found", (cnt < 20), 1);
    chk("coinc_pre_pending", bus.src_pending, 3);
    prev_tog = m_tog;
    step(1, 1, 0, 0);
    chk("coinc_toggle",  bus.src_toggle, !prev_tog);
    chk("coinc_pending", bus.src_pending, 3);

    // Reset mid-operation, then a spurious ack flip while idle.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0);
    chk("mid_pending", bus.src_pending, 7);
    chk("mid_busy",    bus.src_busy, 1);
    step(0, 0, 1, 0);
    chk("mid_rst_toggle",  bus.src_toggle, 0);
    chk("mid_rst_pending", bus.src_pending, 0);
    chk("mid_rst_busy",    bus.src_busy, 0);
    chk("mid_rst_full",    bus.src_full, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
    chk("spur_busy",    bus.src_busy, 0);
    chk("spur_toggle",  bus.src_toggle, 0);
    chk("spur_pending", bus.src_pending, 0);

    // Random traffic with occasional ack freezes, clears and resets.
    do_reset();
    mode = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 64 == 0) mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step(($urandom_range(0, 2) == 0), ($urandom_range(0, 299) != 0), mode,
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pulse_tx_sync.md
Name: pulse_tx_sync

Overview:
Source-domain transmitter for the toggle-based pulse synchronizer. It converts single-cycle src_pulse events into src_toggle transitions for the destination-side pulse synchronizer. The destination echoes its synchronized toggle back as an acknowledge, which this block synchronizes internally. Events arriving while a transfer is outstanding are queued in a saturating pending counter, so no event is lost up to the counter capacity.

Parameters:
DEPTH, 2, number of synchronizer flops on dst_ack_toggle (minimum 2).
CNT_W, 4, width of the pending-event counter; capacity is 2^CNT_W-1 queued events.
RST_VAL, 0, reset value of src_toggle and of every ack synchronizer flop; must match the destination RST_VAL.

Ports:
src_clk  input  1  source clock; single clock domain.
src_rst_n  input  1  synchronous, active-low reset.
src_pulse  input  1  single-cycle event request; each cycle high counts as one event.
dst_ack_toggle  input  1  asynchronous acknowledge toggle, driven by the destination dst_toggle.
src_toggle  output  1  registered toggle sent to the destination synchronizer.
src_busy  output  1  high while a launched transfer awaits acknowledge.
src_pending  output  CNT_W  number of queued events not yet launched.
src_full  output  1  high when src_pending == 2^CNT_W-1.

Behaviour:
- Reset is synchronous, active-low, sampled on the src_clk rising edge. At reset: src_toggle=RST_VAL, all ack sync flops=RST_VAL, state=IDLE, src_pending=0, src_busy=0, src_full=0.
- ack_s is the last stage of a DEPTH-flop chain clocked by src_clk on dst_ack_toggle. There is no reset-domain crossing logic beyond this chain.
- FSM has two states: IDLE and WAIT_ACK. src_busy = (state==WAIT_ACK), registered via the state.
- launch_ok = (IDLE) or (WAIT_ACK and ack_s==src_toggle).
- want = src_pulse or (src_pending != 0).
- When launch_ok and want:
  - src_toggle flips on the next edge; state becomes WAIT_ACK.
  - Launches are back-to-back: on ack match, the next transfer starts in the same cycle with no IDLE gap.
- When state is WAIT_ACK, ack_s==src_toggle, and want is low: state becomes IDLE.
- Bypass: in IDLE with src_pending==0, src_pulse launches directly and src_pending stays 0. Latency is src_pulse at cycle N to src_toggle change visible at cycle N+1.
- Counter update per cycle:
  - inc = src_pulse and not consumed by a bypass launch.
  - dec = launch taken from the queue.
  - inc and dec together: unchanged. inc only: +1. dec only: -1.
- When src_full and inc and not dec: the event is dropped and the counter holds at max. The counter never wraps.
- When src_pulse and a queue launch coincide: the queued event is launched and the new event is queued (net 0).
- Acknowledge latency: after a dst_ack_toggle change at cycle t, the match is seen at t+DEPTH, and state/src_busy update at t+DEPTH+1.
- ack_s changes while IDLE are ignored.
- Reset mid-operation: queued and in-flight events are discarded. The destination must be reset in the same reset event; otherwise the first post-reset launch can complete on a stale ack.
- src_pulse asserted during reset is ignored.

Optional Feature:
PULSE_TX_SYNC_OVF_EN
- Defined:
  - Adds input src_ovf_clr (1) and output src_ovf (1).
  - src_ovf is sticky. It is set the cycle after an event is dropped at full, and cleared the cycle after src_ovf_clr.
  - Simultaneous set and clear: set wins.
  - Reset value is 0.
- Not defined: neither port exists, and dropped events are silent.

Test Plan:
1. Bench setup for all tests: DEPTH=2, CNT_W=4, RST_VAL=0, loopback dst_ack_toggle = src_toggle delayed 3 cycles.
2. Single event: src_pulse at cycle 10 -> src_toggle 0->1 and src_busy=1 at 11; ack changes at 14; src_busy=0 at 17; src_pending remains 0 throughout.
3. Burst: src_pulse high for cycles 10-14 -> src_pending peaks at 4; exactly 5 src_toggle transitions (final value 1); launches back-to-back with no IDLE between; src_busy drops only after the 5th ack.
4. Saturation: ack frozen, 17 consecutive pulses -> src_pending=15 and src_full=1; 17th event dropped. With PULSE_TX_SYNC_OVF_EN, src_ovf=1 and src_ovf_clr clears it. After ack release, 16 total transitions occur.
5. Simultaneous pulse and queue launch: src_pending=3, src_pulse on the ack-match cycle -> src_toggle flips and src_pending stays 3.
6. Reset mid-operation with src_pending=7 and src_busy=1: src_rst_n low one cycle -> next cycle src_toggle=0, src_pending=0, src_busy=0, src_full=0. A spurious dst_ack_toggle flip while IDLE causes no state change.
